// File: rtl/conv_accumulator_pkg.sv
// Shared constants for the power-of-two coefficient
// convolution accumulator: state codes, stage codes, widths.
package conv_accumulator_pkg;

  localparam int DEF_NUM_GROUPS = 16;
  localparam int DEF_ACC_W      = 40;
  localparam int DEF_X_W        = 16;

  localparam int SIGN_GUARD  = 8;
  localparam int ALIGN_GUARD = 16;

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_RJ_ADDR    = 4'd1;
  localparam logic [3:0] S_RJ_LOAD    = 4'd2;
  localparam logic [3:0] S_COEF_ADDR  = 4'd3;
  localparam logic [3:0] S_X_ADDR     = 4'd4;
  localparam logic [3:0] S_ACCUM      = 4'd5;
  localparam logic [3:0] S_SHIFT      = 4'd6;
  localparam logic [3:0] S_SHIFT_LOAD = 4'd7;
  localparam logic [3:0] S_DONE       = 4'd8;

  localparam logic [2:0] CS_IDLE  = 3'b000;
  localparam logic [2:0] CS_ACCUM = 3'b010;
  localparam logic [2:0] CS_SHIFT = 3'b001;
  localparam logic [2:0] CS_DONE  = 3'b100;

endpackage

// File: rtl/conv_accumulator_x_align.sv
// Sign-extends a sample, aligns it into the accumulator
// with low guard bits, and optionally negates it.
module x_align
  import conv_accumulator_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int X_W   = DEF_X_W
) (
  input  logic [X_W-1:0]   x,
  input  logic             neg,
  output logic [ACC_W-1:0] term
);

  localparam int SG = ACC_W - X_W - ALIGN_GUARD;

  logic [ACC_W-1:0] ext;

  assign ext  = {{SG{x[X_W-1]}}, x, {ALIGN_GUARD{1'b0}}};
  assign term = neg ? -ext : ext;

endmodule

// File: rtl/conv_accumulator.sv
// Sequences group/coefficient fetches, accumulates signed
// sample terms, and drives an external one-bit shifter.
module conv_accumulator
  import conv_accumulator_pkg::*;
#(
  parameter int NUM_GROUPS = DEF_NUM_GROUPS,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int X_W        = DEF_X_W
) (
  input  logic             Sclk,
  input  logic             Reset,
  input  logic             start,
  input  logic [7:0]       n_ptr,
  input  logic             filled,
  output logic [3:0]       rj_addr,
  input  logic [15:0]      rj_data,
  output logic [8:0]       coeff_addr,
  input  logic [8:0]       coeff_data,
  output logic [7:0]       x_addr,
  input  logic [X_W-1:0]   x_data,
  output logic [ACC_W-1:0] acc,
  output logic [2:0]       calc_stage,
  input  logic [ACC_W-1:0] shift_data,
  output logic [ACC_W-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] LAST_G = 4'(NUM_GROUPS - 1);

  logic [3:0]       state;
  logic [3:0]       nxt;
  logic [3:0]       group;
  logic [15:0]      remaining;
  logic [7:0]       k;
  logic [7:0]       x_q;
  logic             neg;
  logic             skip;
  logic [ACC_W-1:0] term;

  assign rj_addr = group;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign skip    = !filled && (k > n_ptr);

  // Data address must reach memory in X_ADDR itself
  assign x_addr = (state == S_X_ADDR) ?
                  n_ptr - coeff_data[7:0] : x_q;

  x_align #(
    .ACC_W(ACC_W),
    .X_W  (X_W)
  ) u_align (
    .x   (x_data),
    .neg (neg),
    .term(term)
  );

  // Next-state selection
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:       if (start) nxt = S_RJ_ADDR;
      S_RJ_ADDR:    nxt = S_RJ_LOAD;
      S_RJ_LOAD:    nxt = (rj_data == 16'd0) ?
                          S_SHIFT : S_COEF_ADDR;
      S_COEF_ADDR:  nxt = S_X_ADDR;
      S_X_ADDR:     nxt = S_ACCUM;
      S_ACCUM:      nxt = (remaining == 16'd1) ?
                          S_SHIFT : S_COEF_ADDR;
      S_SHIFT:      nxt = S_SHIFT_LOAD;
      S_SHIFT_LOAD: nxt = (group < LAST_G) ?
                          S_RJ_ADDR : S_DONE;
      S_DONE:       nxt = S_IDLE;
      default:      nxt = S_IDLE;
    endcase
  end

  // Stage code seen by the shifter and status logic
  always_comb begin
    calc_stage = CS_IDLE;
    unique case (state)
      S_RJ_ADDR,
      S_RJ_LOAD,
      S_COEF_ADDR,
      S_X_ADDR,
      S_ACCUM,
      S_SHIFT_LOAD: calc_stage = CS_ACCUM;
      S_SHIFT:      calc_stage = CS_SHIFT;
      S_DONE:       calc_stage = CS_DONE;
      default:      calc_stage = CS_IDLE;
    endcase
  end

  // State, counters, accumulator and result registers
  always_ff @(posedge Sclk) begin
    if (Reset) begin
      state      <= S_IDLE;
      acc        <= '0;
      result     <= '0;
      group      <= '0;
      coeff_addr <= '0;
      x_q        <= '0;
      remaining  <= '0;
      k          <= '0;
      neg        <= 1'b0;
    end else begin
      state <= nxt;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            acc        <= '0;
            group      <= '0;
            coeff_addr <= '0;
          end
        end
        S_RJ_LOAD: remaining <= rj_data;
        S_X_ADDR: begin
          k   <= coeff_data[7:0];
          neg <= coeff_data[8];
          x_q <= x_addr;
        end
        S_ACCUM: begin
          if (!skip) acc <= acc + term;
          coeff_addr <= coeff_addr + 9'd1;
          remaining  <= remaining - 16'd1;
        end
        S_SHIFT_LOAD: begin
          acc <= shift_data;
          if (group < LAST_G) group  <= group + 4'd1;
          else                result <= shift_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_accumulator.sv
// Scoreboard bench for conv_accumulator with behavioural
// rj/coefficient/data memories and an external shifter.
module tb_conv_accumulator;

  logic        Sclk = 1'b0;
  logic        Reset;
  logic        start;
  logic [7:0]  n_ptr;
  logic        filled;
  logic [3:0]  rj_addr;
  logic [15:0] rj_data;
  logic [8:0]  coeff_addr;
  logic [8:0]  coeff_data;
  logic [7:0]  x_addr;
  logic [15:0] x_data;
  logic [39:0] acc;
  logic [2:0]  calc_stage;
  logic [39:0] shift_data;
  logic [39:0] result;
  logic        busy;
  logic        done;

  logic [15:0] rj_mem [16];
  logic [8:0]  coef_mem [512];
  logic [15:0] x_mem [256];

  typedef struct {
    logic [39:0] res;
    int          lat;
  } exp_t;

  exp_t        sb [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          n_done = 0;
  int          n_shift = 0;
  logic [39:0] sh_acc [16];

  conv_accumulator dut (
    .Sclk      (Sclk),
    .Reset     (Reset),
    .start     (start),
    .n_ptr     (n_ptr),
    .filled    (filled),
    .rj_addr   (rj_addr),
    .rj_data   (rj_data),
    .coeff_addr(coeff_addr),
    .coeff_data(coeff_data),
    .x_addr    (x_addr),
    .x_data    (x_data),
    .acc       (acc),
    .calc_stage(calc_stage),
    .shift_data(shift_data),
    .result    (result),
    .busy      (busy),
    .done      (done)
  );

  always #5 Sclk = ~Sclk;

  assign shift_data = {acc[39], acc[39:1]};

  always @(posedge Sclk) begin
    rj_data    <= rj_mem[rj_addr];
    coeff_data <= coef_mem[coeff_addr];
    x_data     <= x_mem[x_addr];
    cyc        <= cyc + 1;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               tag, obs, exp);
    end
  endtask

  always @(negedge Sclk) begin
    exp_t e;
    if (calc_stage == 3'b001) begin
      if (n_shift < 16) sh_acc[n_shift] = acc;
      n_shift++;
    end
    if (done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("latency", cyc - start_cyc, e.lat);
      end
    end
  end

  function automatic logic [39:0] model(output int s);
    logic [39:0] a;
    logic [8:0]  cp;
    logic [8:0]  c;
    logic [7:0]  ia;
    logic [15:0] xv;
    logic [39:0] t;
    a  = '0;
    cp = '0;
    s  = 0;
    for (int g = 0; g < 16; g++) begin
      for (int r = 0; r < int'(rj_mem[g]); r++) begin
        c = coef_mem[cp];
        if (filled || c[7:0] <= n_ptr) begin
          ia = n_ptr - c[7:0];
          xv = x_mem[ia];
          t  = {{8{xv[15]}}, xv, 16'h0000};
          a  = c[8] ? a - t : a + t;
        end
        cp = cp + 9'd1;
        s++;
      end
      a = {a[39], a[39:1]};
    end
    return a;
  endfunction

  task automatic clr();
    for (int i = 0; i < 16; i++)  rj_mem[i] = '0;
    for (int i = 0; i < 512; i++) coef_mem[i] = '0;
    for (int i = 0; i < 256; i++) x_mem[i] = '0;
  endtask

  task automatic run(input int poke);
    exp_t e;
    int   s;
    int   d0;
    e.res = model(s);
    e.lat = 64 + 3 * s;
    sb.push_back(e);
    d0      = n_done;
    n_shift = 0;
    @(posedge Sclk);
    #1 start = 1'b1;
    @(posedge Sclk);
    #1 start = 1'b0;
    start_cyc = cyc;
    for (int i = 0; i < 3000 && n_done == d0; i++) begin
      @(posedge Sclk);
      if (i == poke) begin
        #1 start = 1'b1;
        @(posedge Sclk);
        #1 start = 1'b0;
      end
    end
    if (n_done == d0) chk("timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int d0;
    Reset  = 1'b1;
    start  = 1'b1;
    n_ptr  = '0;
    filled = 1'b0;
    clr();
    repeat (3) @(posedge Sclk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_stage", calc_stage, 0);
    chk("rst_acc", acc, 0);
    chk("rst_result", result, 0);
    chk("rst_done", done, 0);
    chk("rst_rj_addr", rj_addr, 0);
    chk("rst_coeff_addr", coeff_addr, 0);
    chk("rst_x_addr", x_addr, 0);
    start = 1'b0;
    Reset = 1'b0;

    filled = 1'b1;
    run(-1);
    chk("t36_shifts", n_shift, 16);
    chk("t36_result", result, 40'h0);

    clr();
    n_ptr     = 8'd10;
    x_mem[10] = 16'h4000;
    rj_mem[0] = 16'd1;
    run(-1);
    chk("t37_acc", sh_acc[0], 40'h0040000000);
    chk("t37_result", result, 40'h0000004000);

    clr();
    n_ptr       = 8'd7;
    x_mem[7]    = 16'h0001;
    rj_mem[15]  = 16'd1;
    coef_mem[0] = 9'h100;
    run(-1);
    chk("t38_acc", sh_acc[15], 40'hFFFFFF0000);
    chk("t38_result", result, 40'hFFFFFF8000);

    clr();
    n_ptr       = 8'd2;
    rj_mem[0]   = 16'd1;
    coef_mem[0] = 9'd5;
    x_mem[253]  = 16'h0123;
    filled      = 1'b1;
    run(-1);
    chk("t39_x_addr", x_addr, 8'd253);
    chk("t39_filled", result, 40'h123);
    filled = 1'b0;
    run(-1);
    chk("t39_skip", result, 40'h0);

    for (int it = 0; it < 5; it++) begin
      clr();
      for (int i = 0; i < 16; i++)
        rj_mem[i] = 16'($urandom_range(0, 3));
      for (int i = 0; i < 512; i++)
        coef_mem[i] = 9'($urandom);
      for (int i = 0; i < 256; i++)
        x_mem[i] = 16'($urandom);
      n_ptr  = 8'($urandom);
      filled = 1'($urandom);
      run(-1);
    end

    clr();
    n_ptr     = 8'd4;
    x_mem[4]  = 16'h7FFF;
    rj_mem[0] = 16'd1;
    filled    = 1'b1;
    @(posedge Sclk);
    #1 start = 1'b1;
    @(posedge Sclk);
    #1 start = 1'b0;
    repeat (4) @(posedge Sclk);
    #1;
    chk("accum_stage", calc_stage, 3'b010);
    Reset = 1'b1;
    @(posedge Sclk);
    #1;
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_stage", calc_stage, 0);
    chk("mid_rst_busy", busy, 0);
    Reset = 1'b0;

    clr();
    n_ptr       = 8'd9;
    x_mem[9]    = 16'hC000;
    x_mem[6]    = 16'h1234;
    rj_mem[3]   = 16'd2;
    coef_mem[0] = 9'h000;
    coef_mem[1] = 9'h103;
    d0 = n_done;
    run(10);
    repeat (150) @(posedge Sclk);
    chk("one_done", n_done - d0, 1);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
